// File: rtl/hilo_mac_unit_pkg.sv
// hilo_pkg: op codes, FSM encoding and widths shared by the decoder and the HI/LO unit
package hilo_pkg;
  localparam int DATA_W = 32;
  localparam int PROD_W = 64;
  localparam logic [4:0] OP_MUL   = 5'b10010;
  localparam logic [4:0] OP_MULTU = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MULT  = 5'b10110;
  localparam logic [4:0] OP_MFLO  = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;
  localparam logic [4:0] OP_MFHI  = 5'b11011;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  function automatic logic is_mul(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULTU, OP_MADD, OP_MSUB, OP_MULT};
  endfunction
  function automatic logic is_move(input logic [4:0] op);
    return op inside {OP_MFLO, OP_MTHI, OP_MTLO, OP_MFHI};
  endfunction
endpackage

// File: rtl/hilo_mac_unit_if.sv
// hilo_mac_unit_if: request/response and HI/LO bundle between the EX stage and the MAC unit
interface hilo_mac_unit_if;
  import hilo_pkg::*;
  logic              Start;
  logic [4:0]        ALUInstruction;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Result;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  modport master(output Start, ALUInstruction, A, B, input Busy, Done, Result, HI, LO);
  modport slave(input Start, ALUInstruction, A, B, output Busy, Done, Result, HI, LO);
endinterface

// File: rtl/hilo_mac_unit_seq_umult32.sv
// seq_umult32: unsigned 32x32 shift-add multiplier, one multiplier bit per cycle LSB first
module seq_umult32
  import hilo_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Valid,
  output logic [PROD_W-1:0] Prod
);
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [5:0]        cnt;
  logic              run;
  // Valid flags the final iteration so the parent leaves RUN on the same edge it completes
  assign Valid = run && cnt == 6'd31;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      Prod   <= '0;
    end else if (Load) begin
      mcand  <= A;
      mplier <= B;
      cnt    <= '0;
      run    <= 1'b1;
      Prod   <= '0;
    end else if (run) begin
      Prod <= Prod + (mplier[cnt[4:0]] ? {{DATA_W{1'b0}}, mcand} << cnt[4:0] : '0);
      cnt  <= cnt + 6'd1;
      run  <= !Valid;
    end
endmodule

// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit: iterative multiply/accumulate unit owning the HI/LO register pair
module hilo_mac_unit
  import hilo_pkg::*;
(
  input logic            Clk,
  input logic            Reset,
  hilo_mac_unit_if.slave bus
);
  state_t            state, state_nx;
  logic [4:0]        op;
  logic              sign, load, move, signed_op, valid;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [PROD_W-1:0] prod, p, hilo;
  seq_umult32 u_mult (
    .Clk(Clk), .Reset(Reset), .Load(load), .A(mag_a), .B(mag_b), .Valid(valid), .Prod(prod)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (load ? RUN : IDLE) : state == RUN ? (valid ? FINISH : RUN) : IDLE;
  always_comb begin
    bus.Busy = state != IDLE;
    load     = state == IDLE && bus.Start && is_mul(bus.ALUInstruction);
    move     = state == IDLE && bus.Start && is_move(bus.ALUInstruction);
  end
  // The multiplier only sees magnitudes; the sign is reapplied once the product is complete
  always_comb begin
    signed_op = bus.ALUInstruction != OP_MULTU;
    mag_a     = signed_op && bus.A[DATA_W-1] ? -bus.A : bus.A;
    mag_b     = signed_op && bus.B[DATA_W-1] ? -bus.B : bus.B;
    p         = sign ? -prod : prod;
    hilo      = {bus.HI, bus.LO};
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      op         <= '0;
      sign       <= 1'b0;
      bus.Done   <= 1'b0;
      bus.Result <= '0;
      bus.HI     <= '0;
      bus.LO     <= '0;
    end else begin
      bus.Done <= move || state == FINISH;
      if (load) begin
        op   <= bus.ALUInstruction;
        sign <= signed_op && (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
      end
      if (move && bus.ALUInstruction == OP_MTHI) bus.HI <= bus.A;
      if (move && bus.ALUInstruction == OP_MTLO) bus.LO <= bus.A;
      if (move && bus.ALUInstruction == OP_MFHI) bus.Result <= bus.HI;
      if (move && bus.ALUInstruction == OP_MFLO) bus.Result <= bus.LO;
      if (state == FINISH && op == OP_MUL) bus.Result <= p[DATA_W-1:0];
      if (state == FINISH && op != OP_MUL)
        {bus.HI, bus.LO} <= op == OP_MADD ? hilo + p : op == OP_MSUB ? hilo - p : p;
    end
endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb_hilo_mac_unit: table vectors, handshake corner sequences and random ops against an arithmetic model
module tb_hilo_mac_unit;
  import hilo_pkg::*;
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo, res;
  } vec_t;
  logic clk, rst;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi, m_lo, m_res;
  vec_t tbl[14];
  logic [4:0] codes[9];
  hilo_mac_unit_if bus();
  hilo_mac_unit dut (.Clk(clk), .Reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] sp, up, hl;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'b0, a} * {32'b0, b};
    hl = {m_hi, m_lo};
    case (op)
      OP_MULT:  hl = sp;
      OP_MULTU: hl = up;
      OP_MADD:  hl = hl + sp;
      OP_MSUB:  hl = hl - sp;
      OP_MUL:   m_res = sp[31:0];
      OP_MTHI:  hl[63:32] = a;
      OP_MTLO:  hl[31:0] = a;
      OP_MFHI:  m_res = m_hi;
      OP_MFLO:  m_res = m_lo;
      default:  ;
    endcase
    {m_hi, m_lo} = hl;
  endtask

  // Called at a negedge; returns at the negedge where Done is seen (or after the bound)
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    int lat;
    logic busy_ok, mul;
    mul = is_mul(op);
    bus.Start = 1'b1;
    bus.ALUInstruction = op;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    model_apply(op, a, b);
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.Done && lat < 60) begin
      if (bus.Busy !== mul) busy_ok = 1'b0;
      if (lat == poke) begin
        bus.Start = 1'b1;
        bus.ALUInstruction = OP_MTHI;
        bus.A = 32'h12345678;
      end
      @(negedge clk);
      bus.Start = 1'b0;
      lat++;
    end
    if (bus.Busy !== 1'b0) busy_ok = 1'b0;
    chk("latency", 64'(lat), mul ? 64'd34 : 64'd1);
    chk("busy", {63'b0, busy_ok}, 64'd1);
    chk("model_hi", {32'b0, bus.HI}, {32'b0, m_hi});
    chk("model_lo", {32'b0, bus.LO}, {32'b0, m_lo});
    chk("model_result", {32'b0, bus.Result}, {32'b0, m_res});
  endtask

  initial begin
    logic seen;
    codes = '{OP_MUL, OP_MULTU, OP_MADD, OP_MSUB, OP_MULT, OP_MFLO, OP_MTHI, OP_MTLO, OP_MFHI};
    tbl[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
    tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 32'h0};
    tbl[2]  = '{OP_MTHI,  32'h00000000, 32'h0,        32'h00000000, 32'hFFFFFFFE, 32'h0};
    tbl[3]  = '{OP_MTLO,  32'h00000005, 32'h0,        32'h00000000, 32'h00000005, 32'h0};
    tbl[4]  = '{OP_MADD,  32'h00000003, 32'h00000004, 32'h00000000, 32'h00000011, 32'h0};
    tbl[5]  = '{OP_MSUB,  32'h00000011, 32'h00000001, 32'h00000000, 32'h00000000, 32'h0};
    tbl[6]  = '{OP_MSUB,  32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{OP_MUL,   32'h00010000, 32'h00010003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00030000};
    tbl[8]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'h00030000};
    tbl[9]  = '{OP_MFHI,  32'h0,        32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF};
    tbl[10] = '{OP_MFLO,  32'h0,        32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[11] = '{OP_MUL,   32'h80000000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h80000000};
    tbl[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h80000000};
    tbl[13] = '{OP_MADD,  32'hFFFFFFFD, 32'h00000005, 32'h3FFFFFFF, 32'hFFFFFFF1, 32'h80000000};
    m_hi = '0;
    m_lo = '0;
    m_res = '0;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.ALUInstruction = '0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'b0, bus.Busy}, 64'd0);
    chk("reset_done", {63'b0, bus.Done}, 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    chk("reset_result", {32'b0, bus.Result}, 64'd0);
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0);
      chk("tbl_hi", {32'b0, bus.HI}, {32'b0, tbl[i].hi});
      chk("tbl_lo", {32'b0, bus.LO}, {32'b0, tbl[i].lo});
      chk("tbl_result", {32'b0, bus.Result}, {32'b0, tbl[i].res});
    end
    run_op(OP_MUL, 32'h00010000, 32'h00010003, 10);
    chk("mul_result", {32'b0, bus.Result}, 64'h00030000);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.Done) seen = 1'b1;
    end
    chk("no_extra_done", {63'b0, seen}, 64'd0);
    bus.Start = 1'b1;
    bus.ALUInstruction = 5'b00000;
    bus.A = 32'hCAFEF00D;
    @(negedge clk);
    bus.Start = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (bus.Done || bus.Busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("undef_quiet", {63'b0, seen}, 64'd0);
    chk("undef_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});
    chk("undef_result", {32'b0, bus.Result}, {32'b0, m_res});
    bus.Start = 1'b1;
    bus.ALUInstruction = OP_MULT;
    bus.A = 32'h5;
    bus.B = 32'h9;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {63'b0, bus.Busy}, 64'd0);
    chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_res = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) seen = 1'b1;
    end
    chk("abort_no_done", {63'b0, seen}, 64'd0);
    run_op(OP_MULTU, 32'd7, 32'd6, 0);
    chk("post_reset_lo", {32'b0, bus.LO}, 64'd42);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3) == 0 ? 32'h80000000 : $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom;
      run_op(codes[$urandom_range(0, 8)], a, b, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
